// File: rtl/down_counter.sv
// down_counter: loadable modulo-N down counter with IDLE/RUN/DONE control,
// registered busy/done flags and a combinational borrow-out on zero.
module down_counter #(
    parameter longint unsigned N = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] load_val,
    input  logic        en,
    input  logic        abort,
    output logic [31:0] result,
    output logic        bo,
    output logic        busy,
    output logic        done
);
    localparam logic [31:0] MAX = 32'(N - 64'd1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] result_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            result <= result_nx;
            busy   <= state_nx == RUN;
            done   <= state_nx == DONE;
        end
    end
    always_comb begin
        state_nx  = state;
        result_nx = result;
        case (state)
            IDLE: if (start) begin
                state_nx  = RUN;
                result_nx = load_val > MAX ? MAX : load_val;
            end
            RUN: if (abort) state_nx = IDLE;
            else if (en) begin
                state_nx  = result == '0 ? DONE : RUN;
                result_nx = result == '0 ? result : result - 32'd1;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign bo = result == '0;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed scenarios plus randomized traffic checked against
// a flag-based behavioural model of the countdown.
module tb_down_counter;
    localparam int N = 10;
    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, en = 1'b0, abort = 1'b0;
    logic [31:0] load_val = '0;
    logic [31:0] result;
    logic        bo, busy, done;
    logic [34:0] obs, exp;
    int          tests = 0, fails = 0;
    // model: counting flag, pending done pulse and the count itself
    bit          m_busy = 0, m_done = 0;
    logic [31:0] m_res = '0;

    assign obs = {result, bo, busy, done};

    down_counter #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
        .abort(abort), .result(result), .bo(bo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit, want completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_res = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (abort) m_busy = 0;
            else if (en && m_res == 0) begin m_busy = 0; m_done = 1; end
            else if (en) m_res = m_res - 1;
        end else if (start) begin
            m_res  = load_val > 32'(N - 1) ? 32'(N - 1) : load_val;
            m_busy = 1;
        end
        #1;
    endtask

    function automatic logic [34:0] pk(logic [31:0] r, bit b, bit d);
        return {r, r == 0, b, d};
    endfunction

    task automatic test_reset();
        rst = 1; start = 1; load_val = 7; en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = pk(0, 0, 0);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL reset[%0d]: got %h, want %h", i, obs, exp); end
        end
        rst = 0; start = 0; en = 0;
        tick();
        exp = pk(0, 0, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL reset_release: got %h, want %h", obs, exp); end
    endtask

    task automatic test_basic();
        logic [31:0] er [6] = '{3, 2, 1, 0, 0, 0};
        bit          eb [6] = '{1, 1, 1, 1, 0, 0};
        bit          ed [6] = '{0, 0, 0, 0, 1, 0};
        start = 1; load_val = 3; en = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 0;
            exp = pk(er[i], eb[i], ed[i]);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL basic[%0d]: got %h, want %h", i, obs, exp); end
        end
        en = 0;
    endtask

    task automatic test_clamp();
        int n = 0;
        start = 1; load_val = 25; en = 0;
        tick();
        start = 0;
        exp = pk(9, 1, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL clamp_load: got %h, want %h", obs, exp); end
        en = 1;
        while (!done && n < 20) begin tick(); n++; end
        tests++;
        if (n !== 10) begin fails++; $display("FAIL clamp_cycles: got %0d, want 10", n); end
        en = 0;
        tick();
    endtask

    task automatic test_enable();
        bit          es [4] = '{1, 0, 0, 1};
        logic [31:0] er [4] = '{4, 4, 4, 3};
        start = 1; load_val = 5; en = 0;
        tick();
        start = 0;
        exp = pk(5, 1, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL enable_load: got %h, want %h", obs, exp); end
        for (int i = 0; i < 4; i++) begin
            en = es[i];
            tick();
            exp = pk(er[i], 1, 0);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL enable[%0d]: got %h, want %h", i, obs, exp); end
        end
        en = 0; abort = 1;
        tick();
        abort = 0;
        exp = pk(3, 0, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL enable_abort: got %h, want %h", obs, exp); end
    endtask

    task automatic test_abort();
        start = 1; load_val = 4; en = 1;
        tick();
        start = 0;
        tick();
        tick();
        exp = pk(2, 1, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL abort_pre: got %h, want %h", obs, exp); end
        abort = 1;
        tick();
        abort = 0;
        for (int i = 0; i < 4; i++) begin
            exp = pk(2, 0, 0);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL abort[%0d]: got %h, want %h", i, obs, exp); end
            abort = i[0];
            tick();
        end
        en = 0; abort = 0;
    endtask

    task automatic test_zero();
        start = 1; load_val = 0; en = 0;
        tick();
        start = 0;
        exp = pk(0, 1, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL zero_load: got %h, want %h", obs, exp); end
        en = 1;
        tick();
        exp = pk(0, 0, 1);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL zero_done: got %h, want %h", obs, exp); end
        start = 1; load_val = 6;
        tick();
        start = 0;
        exp = pk(0, 0, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL zero_drop: got %h, want %h", obs, exp); end
        tick();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL zero_idle: got %h, want %h", obs, exp); end
        en = 0;
    endtask

    task automatic test_rst_mid();
        start = 1; load_val = 6; en = 1;
        tick();
        start = 0;
        tick();
        tick();
        exp = pk(4, 1, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL rstmid_pre: got %h, want %h", obs, exp); end
        rst = 1; start = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = pk(0, 0, 0);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL rstmid[%0d]: got %h, want %h", i, obs, exp); end
        end
        rst = 0; start = 1; load_val = 0;
        tick();
        start = 0;
        tick();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL rstdone_pre: got done=%0b, want 1", done); end
        rst = 1;
        tick();
        rst = 0; en = 0;
        exp = pk(0, 0, 0);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL rstdone: got %h, want %h", obs, exp); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            rst      = $urandom_range(0, 40) == 0;
            start    = $urandom_range(0, 3) == 0;
            load_val = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
            en       = $urandom_range(0, 3) != 0;
            abort    = $urandom_range(0, 20) == 0;
            tick();
            exp = pk(m_res, m_busy, m_done);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL random[%0d]: got %h, want %h", i, obs, exp); end
        end
        rst = 0; start = 0; en = 0; abort = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_clamp();
        test_enable();
        test_abort();
        test_zero();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
